// File: rtl/elevator_controller.sv
// Four-floor elevator controller: call latching, one-floor-per-TRAVEL_TICKS car motion, door dwell, emergency stop.
// Latency: calls latch one cycle after req; every output is registered and changes one cycle after its cause.
// Backpressure: none; calls accumulate in pend while the car is busy or halted and are served in travel direction.
module elevator_controller #(
  parameter int TICK_DIV     = 25000000,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       stop_btn,
  output logic [1:0] currentFloor,
  output logic       UD_state,
  output logic       OC_state,
  output logic       Stop,
  output logic       pClockTime
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TRAV_LAST  = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_TICKS - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE      = 2'd1;
  localparam logic [1:0] DOOR_OPEN = 2'd2;
  localparam logic [1:0] HALT      = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    floor_q, floor_d;
  logic          ud_q, ud_d;
  logic          oc_q, oc_d;
  logic          stop_q, stop_d;
  logic          pclk_q, pclk_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] trav_q, trav_d;
  logic [DW-1:0] door_q, door_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    clr;
  logic [1:0]    step_floor;
  logic          tick;

  // True when any pending call lies strictly beyond floor f in direction up.
  function automatic logic ahead(input logic [3:0] p, input logic [1:0] f, input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
    end
    return r;
  endfunction

  // Free-running prescaler; tick marks the last count of each period.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pclk_d  = pclk_q ^ tick;
  end

  // Next-state logic: stop_btn overrides everything; servicing a floor raises its clear bit.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    ud_d       = ud_q;
    oc_d       = oc_q;
    trav_d     = trav_q;
    door_d     = door_q;
    clr        = 4'b0000;
    step_floor = floor_q;
    if (stop_btn) begin
      state_d = HALT;
      trav_d  = '0;
      door_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          trav_d = '0;
          door_d = '0;
          if (pend_q[floor_q]) begin
            clr[floor_q] = 1'b1;
            state_d      = DOOR_OPEN;
            oc_d         = 1'b1;
          end else if (ahead(pend_q, floor_q, ud_q)) begin
            state_d = MOVE;
          end else if (ahead(pend_q, floor_q, ~ud_q)) begin
            ud_d    = ~ud_q;
            state_d = MOVE;
          end
        end
        MOVE: begin
          if ((ud_q && floor_q == 2'd3) || (!ud_q && floor_q == 2'd0)) begin
            // Shaft end: never step outside 0..3.
            state_d = IDLE;
            trav_d  = '0;
          end else if (tick) begin
            if (trav_q == TRAV_LAST) begin
              trav_d     = '0;
              step_floor = ud_q ? floor_q + 2'd1 : floor_q - 2'd1;
              floor_d    = step_floor;
              if (pend_q[step_floor]) begin
                clr[step_floor] = 1'b1;
                state_d         = DOOR_OPEN;
                oc_d            = 1'b1;
                door_d          = '0;
              end else if (!ahead(pend_q, step_floor, ud_q)) begin
                state_d = IDLE;
              end
            end else begin
              trav_d = trav_q + 1'b1;
            end
          end
        end
        DOOR_OPEN: begin
          if (pend_q[floor_q]) begin
            // A fresh call at this floor keeps the door open for a full dwell.
            clr[floor_q] = 1'b1;
            door_d       = '0;
          end else if (tick) begin
            if (door_q == DOOR_LAST) begin
              state_d = IDLE;
              oc_d    = 1'b0;
              door_d  = '0;
            end else begin
              door_d = door_q + 1'b1;
            end
          end
        end
        HALT: begin
          // Partial travel is discarded; an open door resumes its dwell from zero.
          trav_d  = '0;
          door_d  = '0;
          state_d = oc_q ? DOOR_OPEN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    pend_d = (pend_q | req) & ~clr;
    stop_d = (state_d == IDLE) || (state_d == HALT);
  end

  // State registers with asynchronous reset to the parked, door-closed, heading-up state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      floor_q <= 2'd0;
      ud_q    <= 1'b1;
      oc_q    <= 1'b0;
      stop_q  <= 1'b1;
      pclk_q  <= 1'b0;
      presc_q <= '0;
      trav_q  <= '0;
      door_q  <= '0;
      pend_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      ud_q    <= ud_d;
      oc_q    <= oc_d;
      stop_q  <= stop_d;
      pclk_q  <= pclk_d;
      presc_q <= presc_d;
      trav_q  <= trav_d;
      door_q  <= door_d;
      pend_q  <= pend_d;
    end
  end

  assign currentFloor = floor_q;
  assign UD_state     = ud_q;
  assign OC_state     = oc_q;
  assign Stop         = stop_q;
  assign pClockTime   = pclk_q;

endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 The block SHALL take parameter TICK_DIV, default 25000000, giving clk cycles per timing tick (benches override to a small value).
REQ-002 The block SHALL take parameter TRAVEL_TICKS, default 4, giving ticks to move one floor.
REQ-003 The block SHALL take parameter DOOR_TICKS, default 3, giving ticks the door stays open.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  4  floor call buttons, bit f = floor f; level-sampled every cycle.
REQ-007 stop_btn  in  1  emergency stop; level-sensitive.
REQ-008 currentFloor  out  2  registered car floor, 0..3.
REQ-009 UD_state  out  1  travel direction: 1 = up, 0 = down.
REQ-010 OC_state  out  1  door: 1 = open, 0 = closed.
REQ-011 Stop  out  1  1 = car not moving (IDLE or HALT).
REQ-012 pClockTime  out  1  tick phase; toggles on every tick.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 free-running and assert a one-cycle internal tick when it equals TICK_DIV-1, then wrap to 0.
REQ-014 Pending register pend[3:0] SHALL set bit f the cycle after req[f] is high, and stay set until serviced.
REQ-015 Servicing floor f SHALL clear pend[f]; if req[f] is high in that same cycle, clear wins and the bit re-sets the following cycle.
REQ-016 The FSM SHALL have exactly four states: IDLE, MOVE, DOOR_OPEN, HALT.
REQ-017 IDLE, pend[currentFloor]=1: go to DOOR_OPEN, clear that bit.
REQ-018 IDLE, no pending bit at currentFloor: if pending requests exist in the UD_state direction, go to MOVE keeping UD_state; else if they exist in the opposite direction, invert UD_state and go to MOVE; else remain IDLE.
REQ-019 MOVE: travel counter SHALL increment per tick; on reaching TRAVEL_TICKS, currentFloor SHALL step by +1 (UD_state=1) or -1 (UD_state=0) and the counter SHALL clear.
REQ-020 At each arrival: pend[new floor]=1 -> DOOR_OPEN, clearing that bit; else requests remaining ahead -> stay in MOVE; else -> IDLE.
REQ-021 currentFloor SHALL never step below 0 or above 3; MOVE SHALL not be entered with no request in the chosen direction.
REQ-022 DOOR_OPEN: OC_state=1; door counter SHALL increment per tick; at DOOR_TICKS the FSM SHALL go to IDLE with OC_state=0.
REQ-023 In DOOR_OPEN, a new pend bit at currentFloor SHALL be cleared and the door counter restarted at 0.
REQ-024 Travel and door counters SHALL clear on every state entry; the prescaler is not restarted, so the first dwell tick may come early.
REQ-025 stop_btn=1 in any state SHALL enter HALT on the next edge; HALT freezes currentFloor, UD_state, OC_state and pend clearing; requests still accumulate.
REQ-026 HALT exit on stop_btn=0: OC_state=1 -> DOOR_OPEN with the door counter cleared; else -> IDLE with the travel counter cleared (partial move aborted, floor unchanged).
REQ-027 Stop SHALL be 1 in IDLE and HALT, 0 in MOVE and DOOR_OPEN; all outputs are registered.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, currentFloor=0, UD_state=1, OC_state=0, Stop=1, pClockTime=0, pend=0, all counters 0.
REQ-029 rst asserted mid-MOVE or mid-DOOR_OPEN SHALL abandon the operation with no residual pending or counter state.

Verification (TICK_DIV=4, TRAVEL_TICKS=2, DOOR_TICKS=3)
REQ-030 Reset, pulse req=4'b1000 -> UD_state=1, Stop=0, currentFloor steps 0->1->2->3 at 8-cycle spacing (first step may be early), then OC_state=1 for 3 ticks, then IDLE, Stop=1, pend=0.
REQ-031 Car at 3 idle, pulse req=4'b0001 -> UD_state=0, car descends to 0, door opens, returns to IDLE.
REQ-032 Car at 0 moving up to 3, pulse req[1] before reaching floor 1 -> stops at 1 with door open, then resumes to 3.
REQ-033 stop_btn=1 mid-MOVE -> HALT, Stop=1, currentFloor frozen; release -> IDLE, then motion resumes to the pending floor.
REQ-034 Hold req[currentFloor] high during DOOR_OPEN -> OC_state stays 1 while held; release -> closes 3 ticks later.
REQ-035 Assert rst mid-DOOR_OPEN with pend=4'b0110 -> all outputs at reset values, pend=0, no motion after rst deasserts.
